// File: rtl/ssd_scanner.sv
// rtl/ssd_scanner.sv - four-digit seven-segment scanner with sequential binary-to-BCD conversion
// Optional feature: SSD_LEADING_ZERO_BLANK_EN blanks leading zero digits (ones digit always lit).
`timescale 1ns/1ps
module ssd_scanner #(
  parameter int REFRESH_BITS = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] displayNumber,
  output logic [3:0]  anode,
  output logic [6:0]  ssdOut,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                  state, state_next;
  logic [REFRESH_BITS-1:0] rc;
  logic [1:0]              sel;
  logic [15:0]             last;
  logic [15:0]             bin;
  logic [15:0]             bcd;
  logic [15:0]             bcd_adj;
  logic [4:0]              cnt;
  logic [3:0][3:0]         digit;
  logic [3:0]              blank;
  logic                    changed;

  assign sel     = rc[REFRESH_BITS-1 -: 2];
  assign busy    = (state != IDLE);
  assign changed = (displayNumber != last);

  // Active-low segment pattern {a..g} for one decimal digit; non-decimal codes go dark.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'b0000001;
      4'd1:    seg_decode = 7'b1001111;
      4'd2:    seg_decode = 7'b0010010;
      4'd3:    seg_decode = 7'b0000110;
      4'd4:    seg_decode = 7'b1001100;
      4'd5:    seg_decode = 7'b0100100;
      4'd6:    seg_decode = 7'b0100000;
      4'd7:    seg_decode = 7'b0001111;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0000100;
      default: seg_decode = 7'b1111111;
    endcase
  endfunction

  // Free-running refresh counter; its top two bits pick the lit digit.
  always_ff @(posedge clk) begin
    if (reset) rc <= '0;
    else       rc <= rc + 1'b1;
  end

  // Conversion FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic: start on input change, leave SHIFT after the 16th shift.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (changed) state_next = SHIFT;
      SHIFT:   if (cnt == 5'd1) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Double-dabble correction: any BCD nibble of 5 or more gets +3 before the shift.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 4; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // Conversion datapath: latch the new value (clamped to 9999), shift, publish digits.
  always_ff @(posedge clk) begin
    if (reset) begin
      last  <= '0;
      bin   <= '0;
      bcd   <= '0;
      cnt   <= '0;
      digit <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (changed) begin
            last <= displayNumber;
            bin  <= (displayNumber > 16'd9999) ? 16'd9999 : displayNumber;
            bcd  <= '0;
            cnt  <= 5'd16;
          end
        end
        SHIFT: begin
          {bcd, bin} <= {bcd_adj[14:0], bin, 1'b0};
          cnt        <= cnt - 5'd1;
        end
        DONE:    digit <= bcd;
        default: ;
      endcase
    end
  end

  // Leading-zero suppression mask; the ones digit is never blanked.
  always_comb begin
    blank = '0;
`ifdef SSD_LEADING_ZERO_BLANK_EN
    blank[3] = (digit[3] == 4'd0);
    blank[2] = (digit[3] == 4'd0) && (digit[2] == 4'd0);
    blank[1] = (digit[3] == 4'd0) && (digit[2] == 4'd0) && (digit[1] == 4'd0);
`else
    blank = '0;
`endif
  end

  // Registered pin drive: one active-low anode plus the selected digit's segments.
  always_ff @(posedge clk) begin
    if (reset) begin
      anode  <= 4'b1111;
      ssdOut <= 7'b1111111;
    end else begin
      anode  <= ~(4'b0001 << sel);
      ssdOut <= blank[sel] ? 7'b1111111 : seg_decode(digit[sel]);
    end
  end

endmodule

// File: tb/tb_ssd_scanner.sv
// tb/tb_ssd_scanner.sv - randomized self-checking bench for ssd_scanner
`timescale 1ns/1ps
module tb_ssd_scanner;

  localparam int RB = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] displayNumber = 16'd0;
  logic [3:0]  anode;
  logic [6:0]  ssdOut;
  logic        busy;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int lastv = 0;
  int len;

  logic [6:0] seg_tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                              7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

  ssd_scanner #(.REFRESH_BITS(RB)) dut (
    .clk(clk),
    .reset(reset),
    .displayNumber(displayNumber),
    .anode(anode),
    .ssdOut(ssdOut),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    if (reset) cyc = 0;
    else       cyc++;
    #1;
  endtask

  // Digit expected on the pins: each digit holds for 2^(RB-2) cycles, starting at the ones digit.
  function automatic int cur_sel();
    return ((cyc - 1) / (1 << (RB - 2))) % 4;
  endfunction

  function automatic logic [6:0] exp_seg(int v, int k);
    int c;
    int p;
    c = (v > 9999) ? 9999 : v;
    p = 1;
    for (int i = 0; i < k; i++) p = p * 10;
`ifdef SSD_LEADING_ZERO_BLANK_EN
    if (k > 0 && c < p) return 7'b1111111;
`endif
    return seg_tab[(c / p) % 10];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic scan(input int v, input int n);
    for (int i = 0; i < n; i++) begin
      int s;
      logic [3:0] ea;
      s  = cur_sel();
      ea = ~(4'b0001 << s);
      check("anode", {28'd0, anode}, {28'd0, ea});
      check("seg", {25'd0, ssdOut}, {25'd0, exp_seg(v, s)});
      tick();
    end
  endtask

  task automatic measure_busy(output int n);
    int g;
    g = 0;
    while (busy !== 1'b1 && g < 40) begin
      tick();
      g++;
    end
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      tick();
    end
  endtask

  task automatic convert(input int v);
    int n;
    displayNumber = v[15:0];
    lastv = v;
    tick();
    check("busy_rise", {31'd0, busy}, 32'd1);
    measure_busy(n);
    check("busy_len", n, 17);
    tick();
    scan(v, 16);
  endtask

  initial begin
    // Reset behaviour and idle scan of zero.
    reset = 1'b1;
    displayNumber = 16'd0;
    repeat (3) tick();
    check("rst_anode", {28'd0, anode}, 32'hf);
    check("rst_seg", {25'd0, ssdOut}, 32'h7f);
    check("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    tick();
    check("idle_busy", {31'd0, busy}, 32'd0);
    scan(0, 16);

    // Basic conversion and clamping.
    convert(1234);
    convert(50000);
    convert(9999);
    convert(50000);

    // Unchanged input starts nothing.
    repeat (3) tick();
    check("no_conv", {31'd0, busy}, 32'd0);

    // Input change mid-conversion: finish 1234, then convert 5678.
    displayNumber = 16'd1234;
    tick();
    check("mid_rise", {31'd0, busy}, 32'd1);
    repeat (4) tick();
    displayNumber = 16'd5678;
    lastv = 5678;
    measure_busy(len);
    check("mid_len1", len, 13);
    check("mid_gap", {31'd0, busy}, 32'd0);
    tick();
    check("mid_rise2", {31'd0, busy}, 32'd1);
    check("mid_old", {25'd0, ssdOut}, {25'd0, exp_seg(1234, cur_sel())});
    measure_busy(len);
    check("mid_len2", len, 17);
    tick();
    scan(5678, 16);

    // Reset during SHIFT aborts and clears the digits.
    displayNumber = 16'd4321;
    tick();
    check("abort_rise", {31'd0, busy}, 32'd1);
    repeat (7) tick();
    reset = 1'b1;
    displayNumber = 16'd77;
    tick();
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_anode", {28'd0, anode}, 32'hf);
    reset = 1'b0;
    lastv = 77;
    tick();
    check("restart_busy", {31'd0, busy}, 32'd1);
    check("cleared_seg", {25'd0, ssdOut}, {25'd0, exp_seg(0, cur_sel())});
    measure_busy(len);
    check("restart_len", len, 17);
    tick();
    scan(77, 16);

    // Leading-zero cases.
    convert(1000);
    convert(42);
    convert(0);

    // Randomized values against the decimal model.
    for (int i = 0; i < 10; i++) begin
      int v;
      if ($urandom_range(0, 3) == 0) v = $urandom_range(0, 65535);
      else                           v = $urandom_range(0, 9999);
      if (v == lastv) v = (v + 1) % 65536;
      convert(v);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ssd_scanner.md
# ssd_scanner

Four-digit seven-segment display driver that consumes the 16-bit score produced by the game/pixel logic and drives the board's multiplexed anodes and cathodes. It performs a sequential binary-to-BCD conversion (double-dabble, one bit per clock) whenever the input value changes, holds the resulting decimal digits in a display register, and time-multiplexes them onto the four right-hand digits. The top level ties the upper four anodes high and maps `ssdOut` to `{Ca..Cg}`.

## Interface
- `REFRESH_BITS`, default 20: width of the free-running refresh counter. Its top two bits select the digit, so each digit is lit for 2^(REFRESH_BITS-2) cycles (2.62 ms at 100 MHz).
- `clk` input 1: the single clock; all logic is on its rising edge.
- `reset` input 1: synchronous, active-high.
- `displayNumber` input 16: unsigned binary value to show.
- `anode` output 4: active-low digit enables. `anode[0]` is the ones digit (rightmost).
- `ssdOut` output 7: active-low segments `{a,b,c,d,e,f,g}`.
- `busy` output 1: high while a conversion is in progress.

## Operation
- Refresh counter `rc[REFRESH_BITS-1:0]` increments every cycle and wraps to 0.
- Digit select is `sel = rc[REFRESH_BITS-1 -: 2]`.
- Conversion FSM states:
  - **IDLE:** if `displayNumber != last`, set `last <= displayNumber` and load the shift register with `min(displayNumber, 9999)`. Clear the BCD accumulator, set the bit counter to 16, then go to SHIFT.
  - **SHIFT:** per cycle, add 3 to every BCD nibble that is ≥5, then shift `{bcd, bin}` left by one and decrement the counter. After the 16th shift, go to DONE.
  - **DONE:** copy the four BCD nibbles into the `digit[3:0]` display register, then go to IDLE.
- `busy` = (state != IDLE).
- Input changes during SHIFT or DONE are ignored. They are re-compared on return to IDLE, so the final value is always converted.
- Clamp: values 10000..65535 display "9999". `last` stores the unclamped value.
- Decode (active-low `{a..g}`):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
  - blank=1111111
- Output register: each cycle `anode <= ~(4'b0001 << sel)` and `ssdOut <= decode(digit[sel])`. Exactly one anode is low at any time after reset.

## Timing
- Reset values:
  - `rc`=0, state=IDLE, `last`=0, `digit`=all 0, `busy`=0
  - `anode`=4'b1111, `ssdOut`=7'b1111111
- First cycle after reset deassert: outputs register from `sel`=0, so `anode`=1110 and `ssdOut`=0000001 one cycle later.
- Conversion latency: mismatch seen in IDLE at cycle N → SHIFT cycles N+1..N+16 → DONE at N+17. The new digits are in `digit` from N+18 and on the pins from N+19 when that digit is selected.
- `busy` is high from cycle N+1 through N+17 inclusive.
- Reset mid-conversion aborts: the FSM returns to IDLE and digits are zeroed. A nonzero `displayNumber` then starts a fresh conversion on the first cycle after reset.
- Segment/anode outputs lag `sel` by one register stage. No ghosting is required beyond this.

## Configuration
- `SSD_LEADING_ZERO_BLANK_EN` defined:
  - Digit k (k=1..3) shows blank when `digit[3:k]` are all zero.
  - Digit 0 is never blanked; its anode stays active.
  - Example: 42 shows "  42", 0 shows "   0".
- Undefined: all four digits always decode, e.g. 42 shows "0042".

## Test plan
Simulate with `REFRESH_BITS`=4.
- **Reset:** hold `reset` 3 cycles → `anode`=1111, `ssdOut`=1111111, `busy`=0. After release, the cycle sequence shows `anode` 1110,1101,1011,0111 with `ssdOut`=0000001 (macro undefined).
- **Conversion:** `displayNumber`=1234 → `busy` high exactly 17 cycles. Afterwards `anode`=1110 shows 1001100 (4), 1101 shows 0000110 (3), 1011 shows 0010010 (2), and 0111 shows 1001111 (1).
- **Clamp:** `displayNumber`=50000 → all digits 0000100 (9). Then 9999→50000: no visible change; a conversion still runs because `last` differs.
- **Mid-conversion change:** 1234, then 5678 five cycles later → first conversion completes (1234 visible), then a second 17-cycle `busy` pulse follows and 5678 is displayed.
- **Reset mid-SHIFT:** assert `reset` at busy cycle 8 → `busy`=0 next cycle. After release with input 77, the display settles to 0077 (or "  77" with the macro).
- **Leading-zero blank (macro defined):** input 0 → digits 3..1 show 1111111 and digit 0 shows 0000001. Input 1000 → all four digits lit.
